// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit bridging EX/MEM fields to a req/ack data bus.
// Define LSU_ALIGN_CHECK_EN to trap misaligned halfword/word accesses (adds lsu_misalign).
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_wen,
    input  logic [31:0] mem_wdata,
    input  logic        mem_hilo_wen,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  wb_waddr,
    output logic        wb_wen,
    output logic [31:0] wb_wdata,
    output logic        wb_hilo_wen,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo
`ifdef LSU_ALIGN_CHECK_EN
    ,
    output logic        lsu_misalign
`endif
);

    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    logic        r_dm_req;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [3:0]  r_dm_be;
    logic [31:0] r_rdata;
    logic [4:0]  r_wb_waddr;
    logic        r_wb_wen;
    logic [31:0] r_wb_wdata;
    logic        r_wb_hilo_wen;
    logic [31:0] r_wb_hi;
    logic [31:0] r_wb_lo;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic [31:0] w_load_val;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [7:0]  w_rbyte [4];
    logic [3:0]  w_sb_be;

    // Little-endian lanes: byte k of the word sits at bits [8k+7:8k].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_rbyte[gi] = r_rdata[8*gi +: 8];
            assign w_sb_be[gi] = (mem_mem_addr[1:0] == 2'(gi));
        end
    endgenerate

    assign w_byte = w_rbyte[mem_mem_addr[1:0]];
    assign w_half = mem_mem_addr[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_be       = 4'b1111;
        w_st_data  = mem_reg2;
        w_load_val = r_rdata;
        case (mem_aluop)
            EXE_LB_OP:  begin w_is_load = 1'b1; w_load_val = {{24{w_byte[7]}}, w_byte}; end
            EXE_LBU_OP: begin w_is_load = 1'b1; w_load_val = {24'd0, w_byte}; end
            EXE_LH_OP:  begin w_is_load = 1'b1; w_load_val = {{16{w_half[15]}}, w_half}; end
            EXE_LHU_OP: begin w_is_load = 1'b1; w_load_val = {16'd0, w_half}; end
            EXE_LW_OP:  w_is_load = 1'b1;
            EXE_SB_OP: begin
                w_is_store = 1'b1;
                w_be       = w_sb_be;
                w_st_data  = {4{mem_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                w_is_store = 1'b1;
                w_be       = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data  = {2{mem_reg2[15:0]}};
            end
            EXE_SW_OP:  w_is_store = 1'b1;
            default: ;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = (((mem_aluop == EXE_LH_OP) || (mem_aluop == EXE_LHU_OP) ||
                          (mem_aluop == EXE_SH_OP)) && mem_mem_addr[0]) ||
                        (((mem_aluop == EXE_LW_OP) || (mem_aluop == EXE_SW_OP)) &&
                          (mem_mem_addr[1:0] != 2'b00));
    logic r_misalign;
    assign lsu_misalign = r_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_is_mem  = w_is_load | w_is_store;
    assign w_start   = w_is_mem & ~w_misalign;
    assign mem_stall = (r_state == S_REQ) || ((r_state == S_IDLE) && w_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_dm_req      <= 1'b0;
            r_dm_we       <= 1'b0;
            r_dm_addr     <= 32'd0;
            r_dm_wdata    <= 32'd0;
            r_dm_be       <= 4'd0;
            r_rdata       <= 32'd0;
            r_wb_waddr    <= 5'd0;
            r_wb_wen      <= 1'b0;
            r_wb_wdata    <= 32'd0;
            r_wb_hilo_wen <= 1'b0;
            r_wb_hi       <= 32'd0;
            r_wb_lo       <= 32'd0;
`ifdef LSU_ALIGN_CHECK_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
`ifdef LSU_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        // Memory ops (issued or trapped) leave a bubble behind them.
                        r_wb_waddr    <= 5'd0;
                        r_wb_wen      <= 1'b0;
                        r_wb_wdata    <= 32'd0;
                        r_wb_hilo_wen <= 1'b0;
                        r_wb_hi       <= 32'd0;
                        r_wb_lo       <= 32'd0;
                        if (w_start) begin
                            r_state    <= S_REQ;
                            r_dm_req   <= 1'b1;
                            r_dm_we    <= w_is_store;
                            r_dm_addr  <= {mem_mem_addr[31:2], 2'b00};
                            r_dm_be    <= w_be;
                            r_dm_wdata <= w_st_data;
                        end else begin
`ifdef LSU_ALIGN_CHECK_EN
                            r_misalign <= 1'b1;
`endif
                        end
                    end else begin
                        r_wb_waddr    <= mem_waddr;
                        r_wb_wen      <= mem_wen;
                        r_wb_wdata    <= mem_wdata;
                        r_wb_hilo_wen <= mem_hilo_wen;
                        r_wb_hi       <= mem_hi;
                        r_wb_lo       <= mem_lo;
                    end
                end
                S_REQ: begin
                    if (dm_ack) begin
                        r_rdata  <= dm_rdata;
                        r_dm_req <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // EX/MEM still holds the op here, so lane selection uses live mem_* fields.
                    r_wb_waddr    <= mem_waddr;
                    r_wb_wen      <= w_is_load & mem_wen;
                    r_wb_wdata    <= w_is_load ? w_load_val : 32'd0;
                    r_wb_hilo_wen <= 1'b0;
                    r_wb_hi       <= 32'd0;
                    r_wb_lo       <= 32'd0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dm_req      = r_dm_req;
    assign dm_we       = r_dm_we;
    assign dm_addr     = r_dm_addr;
    assign dm_wdata    = r_dm_wdata;
    assign dm_be       = r_dm_be;
    assign wb_waddr    = r_wb_waddr;
    assign wb_wen      = r_wb_wen;
    assign wb_wdata    = r_wb_wdata;
    assign wb_hilo_wen = r_wb_hilo_wen;
    assign wb_hi       = r_wb_hi;
    assign wb_lo       = r_wb_lo;

endmodule
